// File: rtl/ntru_polyin_streamer.sv
// AXI-Stream master that replays buffered (poly_1, poly_2) coefficient pairs into the polymul input stream.
// Optional macro NTRU_POLYIN_TERNARY_CHECK_EN builds the sticky illegal-ternary flag coef_err.
module ntru_polyin_streamer #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned P2_W   = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_poly_1,
  input  logic [P2_W-1:0]   wr_poly_2,
  input  logic [9:0]        poly_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              coef_err
);

  localparam int unsigned WORD_W = COEF_W + P2_W;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_q;
  logic              rd_vld;
  logic              rd_last;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [9:0]        n;
  logic [9:0]        rd_cnt;
  logic              hs;
  logic              take;

  function automatic logic [31:0] pack(input logic [WORD_W-1:0] w);
    logic [31:0] t;
    t = '0;
    t[COEF_W-1:0] = w[COEF_W-1:0];
    t[16 +: P2_W] = w[WORD_W-1:COEF_W];
    return t;
  endfunction

  // rd_q doubles as the skid entry: its read enable is withheld while the output register is stalled.
  always_comb begin
    hs      = m_axis_tvalid && m_axis_tready;
    take    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = ADDR_W'(rd_cnt);
    case (state)
      IDLE: begin
        if (start && poly_n != 10'd0) begin
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      PRIME, STREAM: begin
        take  = rd_vld && (!m_axis_tvalid || hs);
        rd_en = (rd_cnt != n) && (!rd_vld || take);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= {wr_poly_2, wr_poly_1};
    if (rd_en) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      n             <= '0;
      rd_cnt        <= '0;
      rd_vld        <= 1'b0;
      rd_last       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
`ifdef NTRU_POLYIN_TERNARY_CHECK_EN
      coef_err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n <= poly_n;
`ifdef NTRU_POLYIN_TERNARY_CHECK_EN
            coef_err <= 1'b0;
`endif
            if (poly_n == 10'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= PRIME;
              busy    <= 1'b1;
              rd_cnt  <= 10'd1;
              rd_vld  <= 1'b1;
              rd_last <= (poly_n == 10'd1);
            end
          end
        end
        PRIME, STREAM: begin
          if (take) begin
            m_axis_tdata  <= pack(rd_q);
            m_axis_tlast  <= rd_last;
            m_axis_tvalid <= 1'b1;
          end else if (hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
          if (rd_en) begin
            rd_cnt  <= rd_cnt + 10'd1;
            rd_last <= (rd_cnt == n - 10'd1);
            rd_vld  <= 1'b1;
          end else if (take) begin
            rd_vld  <= 1'b0;
          end
`ifdef NTRU_POLYIN_TERNARY_CHECK_EN
          if (hs && m_axis_tdata[16 +: P2_W] == {P2_W{1'b1}}) coef_err <= 1'b1;
`endif
          if (state == PRIME) state <= STREAM;
          if (hs && m_axis_tlast) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef NTRU_POLYIN_TERNARY_CHECK_EN
  assign coef_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntru_polyin_streamer.sv
// Scoreboard bench for ntru_polyin_streamer: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ntru_polyin_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [12:0] wr_poly_1 = '0;
  logic [1:0]  wr_poly_2 = '0;
  logic [9:0]  poly_n = '0;
  logic        start = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        busy, done, m_axis_tvalid, m_axis_tlast, coef_err;
  logic [31:0] m_axis_tdata;

`ifdef NTRU_POLYIN_TERNARY_CHECK_EN
  localparam logic CE_EXP = 1'b1;
`else
  localparam logic CE_EXP = 1'b0;
`endif

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          beats_seen = 0;
  int          last_hs_cyc = 0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  logic        pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [32:0] sb [$];
  logic [31:0] model [1024];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  ntru_polyin_streamer #(.COEF_W(13), .P2_W(2), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_poly_1(wr_poly_1), .wr_poly_2(wr_poly_2), .poly_n(poly_n), .start(start),
    .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .coef_err(coef_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = (pat_idx < 7) ? pat[pat_idx] : 1'b1;
        pat_idx++;
      end
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got 0x%08h with empty scoreboard", m_axis_tdata);
        end else begin
          e = sb.pop_front();
          chk("beat_tdata", m_axis_tdata, e[31:0]);
          chk("beat_tlast", 32'(m_axis_tlast), 32'(e[32]));
        end
        beats_seen++;
        if (m_axis_tlast) last_hs_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic wr(input int a, input logic [12:0] p1, input logic [1:0] p2, input bit upd);
    wr_en = 1'b1; wr_addr = 10'(a); wr_poly_1 = p1; wr_poly_2 = p2;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (upd) model[a] = {14'b0, p2, 3'b0, p1};
  endtask

  task automatic go(input int n, output int sc);
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), model[i]});
    pat_idx = 0; poly_n = 10'(n); start = 1'b1; sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dc, output bit saw_valid);
    dc = -1; saw_valid = 1'b0;
    for (int i = 0; i < limit && dc < 0; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) saw_valid = 1'b1;
      if (done) dc = cyc;
    end
    if (dc < 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, required done within %0d cycles", limit);
    end
  endtask

  task automatic finish_stream(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic load_basic();
    wr(0, 13'h0001, 2'b01, 1'b0); wr(1, 13'h1FFF, 2'b10, 1'b0);
    wr(2, 13'h0AAA, 2'b00, 1'b0); wr(3, 13'h0555, 2'b01, 1'b0);
    model[0] = 32'h00010001; model[1] = 32'h00021FFF;
    model[2] = 32'h00000AAA; model[3] = 32'h00010555;
  endtask

  initial begin
    int sc, dc;
    bit sv;
    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_coef_err", 32'(coef_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // full-throughput 4-word stream
    load_basic();
    ready_mode = 0;
    go(4, sc);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(50, dc, sv);
    chk("n4_done_latency", 32'(dc - sc), 32'd6);
    finish_stream("n4");

    // backpressure pattern
    ready_mode = 1;
    go(4, sc);
    wait_done(50, dc, sv);
    chk("bp_done_after_last_hs", 32'(dc - last_hs_cyc), 32'd1);
    finish_stream("bp");

    // single word and empty stream
    ready_mode = 0;
    go(1, sc);
    wait_done(50, dc, sv);
    chk("n1_done_latency", 32'(dc - sc), 32'd3);
    finish_stream("n1");
    go(0, sc);
    wait_done(10, dc, sv);
    chk("n0_no_valid", 32'(sv), 32'd0);
    chk("n0_done_latency", 32'(dc - sc), 32'd1);
    finish_stream("n0");

    // long stream, random ready, ignored start and write while busy
    for (int i = 0; i < 1023; i++) wr(i, 13'(i * 37 + 5), 2'(i % 3), 1'b1);
    ready_mode = 2;
    go(1023, sc);
    repeat (60) @(posedge clk);
    #1;
    start = 1'b1; poly_n = 10'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    wr(1000, 13'h1234, 2'b10, 1'b0);
    wait_done(20000, dc, sv);
    finish_stream("n1023");

    // asynchronous reset in the middle of beat 2
    load_basic();
    ready_mode = 0;
    beats_seen = 0;
    go(4, sc);
    for (int i = 0; i < 20 && beats_seen < 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    go(4, sc);
    wait_done(50, dc, sv);
    finish_stream("post_rst");

    // illegal ternary code at address 2
    wr(2, 13'h0AAA, 2'b11, 1'b0);
    model[2] = 32'h00030AAA;
    beats_seen = 0;
    go(4, sc);
    for (int i = 0; i < 20 && beats_seen < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("coef_err_before_hs3", 32'(coef_err), 32'd0);
    @(negedge clk); #1;
    chk("coef_err_after_hs3", 32'(coef_err), 32'(CE_EXP));
    wait_done(50, dc, sv);
    finish_stream("tern");
    chk("coef_err_sticky", 32'(coef_err), 32'(CE_EXP));
    go(0, sc);
    chk("coef_err_cleared", 32'(coef_err), 32'd0);
    wait_done(10, dc, sv);
    finish_stream("tern_clr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
